led_pattern_ctrl: RTL

Parametrised successor to the board-level LED controller. Single self-contained block driving three RGB LED banks of NB_LEDS bits from one pattern engine. It contains an internal rate prescaler and four pattern modes (shift, flash, bounce, binary count) selected by a button. Buttons are edge-detected and the colour channels are individually toggled, so colours can be mixed.

---
 rtl/led_pattern_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: one pattern engine feeding three RGB LED banks.
// A run/rate prescaler paces the engine, a button cycles through four
// pattern modes, and three buttons toggle the colour channels so colours mix.
module led_pattern_ctrl #(
    parameter int NB_LEDS    = 4,
    parameter int NB_SW      = 4,
    parameter int NB_BTN     = 4,
    parameter int NB_COUNTER = 32,
    parameter int RATE_BASE  = 2**20
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic [NB_SW-1:0]   i_sw,
    input  logic [NB_BTN-1:0]  i_btn,
    output logic [NB_LEDS-1:0] o_led_r,
    output logic [NB_LEDS-1:0] o_led_g,
    output logic [NB_LEDS-1:0] o_led_b,
    output logic [1:0]         o_mode,
    output logic               o_tick
);

    typedef enum logic [1:0] {
        MODE_SHIFT  = 2'd0,
        MODE_FLASH  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_t;

    mode_t               mode;
    mode_t               mode_next;
    logic [NB_BTN-1:0]   btn_prev;
    logic [NB_BTN-1:0]   btn_edge;
    logic                mode_edge;
    logic                run;
    logic                reverse;
    logic [1:0]          rate_sel;
    logic [NB_COUNTER-1:0] counter;
    logic [NB_COUNTER-1:0] period_m1;
    logic                tick_now;
    logic [NB_LEDS-1:0]  pattern;
    logic [NB_LEDS-1:0]  pattern_next;
    logic [NB_LEDS-1:0]  pattern_init;
    logic                dir_right;
    logic                dir_right_next;
    logic                en_r;
    logic                en_g;
    logic                en_b;

    assign run       = i_sw[0];
    assign rate_sel  = i_sw[2:1];
    assign reverse   = i_sw[3];
    assign btn_edge  = i_btn & ~btn_prev;
    assign mode_edge = btn_edge[0];

    // The comparison is >= rather than == so that switching to a faster rate
    // while the counter is already past the new end still wraps on the next cycle.
    assign period_m1 = (NB_COUNTER'(RATE_BASE) << rate_sel) - NB_COUNTER'(1);
    assign tick_now  = run && (counter >= period_m1);

    // Mode register.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            mode <= MODE_SHIFT;
        end else begin
            mode <= mode_next;
        end
    end

    // Next mode: a rising edge on the mode button steps round the four modes.
    always_comb begin
        mode_next = mode;
        if (mode_edge) begin
            case (mode)
                MODE_SHIFT:  mode_next = MODE_FLASH;
                MODE_FLASH:  mode_next = MODE_BOUNCE;
                MODE_BOUNCE: mode_next = MODE_COUNT;
                default:     mode_next = MODE_SHIFT;
            endcase
        end
    end

    // Mode output is the state register itself.
    always_comb begin
        o_mode = mode;
    end

    // Starting pattern of the mode being entered.
    always_comb begin
        pattern_init = '0;
        case (mode_next)
            MODE_SHIFT:  pattern_init = NB_LEDS'(1);
            MODE_BOUNCE: pattern_init = NB_LEDS'(1);
            default:     pattern_init = '0;
        endcase
    end

    // Pattern step taken on a tick; bounce flips direction when the lit bit reaches an end.
    always_comb begin
        pattern_next   = pattern;
        dir_right_next = dir_right;
        case (mode)
            MODE_SHIFT: begin
                if (reverse) begin
                    pattern_next = (pattern >> 1) | (pattern << (NB_LEDS - 1));
                end else begin
                    pattern_next = (pattern << 1) | (pattern >> (NB_LEDS - 1));
                end
            end
            MODE_FLASH: begin
                pattern_next = ~pattern;
            end
            MODE_BOUNCE: begin
                if (NB_LEDS == 1) begin
                    pattern_next = pattern;
                end else begin
                    pattern_next = dir_right ? (pattern >> 1) : (pattern << 1);
                    if (pattern_next[NB_LEDS-1]) begin
                        dir_right_next = 1'b1;
                    end else if (pattern_next[0]) begin
                        dir_right_next = 1'b0;
                    end
                end
            end
            default: begin
                if (reverse) begin
                    pattern_next = pattern - NB_LEDS'(1);
                end else begin
                    pattern_next = pattern + NB_LEDS'(1);
                end
            end
        endcase
    end

    // Button history and colour enables; a held button only acts on its first cycle.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            btn_prev <= i_btn;
            en_r     <= 1'b1;
            en_g     <= 1'b0;
            en_b     <= 1'b0;
        end else begin
            btn_prev <= i_btn;
            en_r     <= en_r ^ btn_edge[1];
            en_g     <= en_g ^ btn_edge[2];
            en_b     <= en_b ^ btn_edge[3];
        end
    end

    // Prescaler and pattern engine; a mode change wins over a tick in the same cycle.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            counter   <= '0;
            pattern   <= NB_LEDS'(1);
            dir_right <= 1'b0;
            o_tick    <= 1'b0;
        end else if (mode_edge) begin
            counter   <= '0;
            pattern   <= pattern_init;
            dir_right <= 1'b0;
            o_tick    <= 1'b0;
        end else if (tick_now) begin
            counter   <= '0;
            pattern   <= pattern_next;
            dir_right <= dir_right_next;
            o_tick    <= 1'b1;
        end else begin
            if (run) begin
                counter <= counter + NB_COUNTER'(1);
            end
            o_tick <= 1'b0;
        end
    end

    // LED banks show the pattern one cycle later, gated by each colour enable.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            o_led_r <= '0;
            o_led_g <= '0;
            o_led_b <= '0;
        end else begin
            o_led_r <= en_r ? pattern : '0;
            o_led_g <= en_g ? pattern : '0;
            o_led_b <= en_b ? pattern : '0;
        end
    end

endmodule
